// File: rtl/mux_nx1_rr_reg_pkg.sv
// Shared constants for the N:1 registered arbitrating multiplexer.
// Holds the mode encodings and the stall-counter width used by the
// optional MUX_NX1_STALL_CNT_EN build.
package mux_nx1_rr_reg_pkg;

  // Arbitration mode encodings driven on the mode input.
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Width of the optional output-stall counter.
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/mux_nx1_rr_reg_arbiter.sv
// rr_arbiter_nx1: purely combinational N-way arbiter.
// Round-robin mode searches upward from ptr (wrapping modulo N); fixed
// mode always searches from channel 0, so the lowest-index request wins.
// Outputs a one-hot grant, the binary index of the winner and any_grant.
module rr_arbiter_nx1
  import mux_nx1_rr_reg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 mode,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);

  localparam int SELW = $clog2(N);

  int start_idx;

  // Search origin: the pointer in round-robin mode, channel 0 in fixed mode.
  // A pointer outside 0..N-1 cannot be produced by the top, but fall back to
  // 0 so the search stays well defined for any input value.
  always_comb begin
    start_idx = 0;
    if (mode == MODE_RR && int'(ptr) < N) begin
      start_idx = int'(ptr);
    end
  end

  // Pick the requesting channel at the smallest wrapped distance from the
  // origin. Scanning distance in the outer loop keeps every bit select on a
  // loop constant, so the logic flattens into a plain priority network.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < N; c++) begin
        if (!any_grant && req[c] && (((c - start_idx) + N) % N) == d) begin
          grant[c]  = 1'b1;
          grant_idx = SELW'(c);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr_reg.sv
// mux_nx1_rr_reg: N-input, WIDTH-bit registered multiplexer with built-in
// round-robin / fixed-priority arbitration and valid/ready on every side.
// One beat per cycle, one cycle from in_ready pulse to out_valid.
// Optional build macro MUX_NX1_STALL_CNT_EN adds a saturating counter of
// output stall cycles (stall_cnt) with a synchronous clear (stall_clr).
module mux_nx1_rr_reg
  import mux_nx1_rr_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_sel
`ifdef MUX_NX1_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
`endif
);

  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  out_sel_reg;
  logic [SELW-1:0]  ptr_reg;
  logic [SELW-1:0]  ptr_next;

  logic             load;
  logic             take;
  logic [N-1:0]     arb_grant;
  logic [SELW-1:0]  arb_idx;
  logic             arb_any;
  logic [WIDTH-1:0] masked_data [N];
  logic [WIDTH-1:0] sel_data;

  // The output register can accept a new beat when empty or being drained.
  assign load = !out_valid_reg || out_ready;
  assign take = load && arb_any;

  rr_arbiter_nx1 #(
    .N (N)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_reg),
    .mode      (mode),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Grant is only advertised upstream when the output register can take it,
  // so a stalled output holds every channel off.
  assign in_ready = load ? arb_grant : '0;

  // AND-OR data select: each channel is gated by its one-hot grant bit.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign masked_data[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{arb_grant[gi]}};
    end
  endgenerate

  // OR-reduce the gated channels into the selected beat.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      sel_data = sel_data | masked_data[k];
    end
  end

  // Next round-robin pointer: one past the winner, wrapping N-1 -> 0.
  // Frozen in fixed-priority mode and whenever nothing is granted.
  always_comb begin
    ptr_next = ptr_reg;
    if (take && mode == MODE_RR) begin
      if (arb_idx == SELW'(N - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = arb_idx + SELW'(1);
      end
    end
  end

  // Output register and pointer; reset discards any in-flight beat at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else begin
      if (load) begin
        if (arb_any) begin
          out_data_reg  <= sel_data;
          out_sel_reg   <= arb_idx;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
      ptr_reg <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sel   = out_sel_reg;

`ifdef MUX_NX1_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  // Count cycles where a beat waits on downstream; clear wins, saturate at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_clr) begin
      stall_cnt_reg <= '0;
    end else if (out_valid_reg && !out_ready && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Self-checking bench for mux_nx1_rr_reg (N=4, WIDTH=32).
// The driver issues directed cycles with hand-computed in_ready values and
// pushes the expected output beat; a monitor pops and compares beats as the
// DUT presents them. The stall-counter section builds only with
// MUX_NX1_STALL_CNT_EN defined.
`timescale 1ns/1ps
module tb_mux_nx1_rr_reg;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mode;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_sel;
`ifdef MUX_NX1_STALL_CNT_EN
  logic [15:0]        stall_cnt;
  logic               stall_clr;
`endif

  logic [WIDTH-1:0] chdata [N];

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
    int unsigned cyc;
  } beat_t;

  beat_t       sb [$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign in_data[gi*WIDTH +: WIDTH] = chdata[gi];
    end
  endgenerate

  mux_nx1_rr_reg #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
`ifdef MUX_NX1_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Monitor: a beat issued in an earlier cycle must be visible; every
  // consumed beat is compared against the oldest expectation.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: out_valid=%0b required 1 (pending sel %0d)", out_valid, sb[0].sel);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: sel=%0d data=%h required no beat", out_sel, out_data);
        end else begin
          b = sb.pop_front();
          if (out_sel !== b.sel || out_data !== b.data) begin
            errors++;
            $display("FAIL beat: sel=%0d data=%h required sel=%0d data=%h",
                     out_sel, out_data, b.sel, b.data);
          end else begin
            $display("beat sel=%0d data=%h", out_sel, out_data);
          end
        end
      end
    end
  end

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One directed cycle: apply inputs, check in_ready, record expected beat.
  task automatic step(input logic m, input logic [3:0] v, input logic r,
                      input logic [3:0] exp_rdy);
    beat_t b;
    int    w;
    @(posedge clk);
    #1;
    mode      = m;
    in_valid  = v;
    out_ready = r;
    @(negedge clk);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b required %b (mode=%0b valid=%b out_ready=%0b)",
               in_ready, exp_rdy, m, v, r);
    end
    if (exp_rdy != 4'b0000) begin
      w      = onehot_idx(exp_rdy);
      b.sel  = w[1:0];
      b.data = chdata[w];
      b.cyc  = cyc_cnt;
      sb.push_back(b);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  logic [31:0] hold;

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
`ifdef MUX_NX1_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) chdata[i] = 32'hA0 + 32'(i);

    #3;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_sel", {30'b0, out_sel}, 32'd0);
    #19 rst_n = 1'b1;

    // Round-robin with all channels requesting: 0,1,2,3,0.
    step(1'b0, 4'b1111, 1'b1, 4'b0001);
    step(1'b0, 4'b1111, 1'b1, 4'b0010);
    step(1'b0, 4'b1111, 1'b1, 4'b0100);
    step(1'b0, 4'b1111, 1'b1, 4'b1000);
    step(1'b0, 4'b1111, 1'b1, 4'b0001);

    // Fixed priority: ch1 over ch3, then ch3 alone; pointer stays at 1.
    step(1'b1, 4'b1010, 1'b1, 4'b0010);
    step(1'b1, 4'b1010, 1'b1, 4'b0010);
    step(1'b1, 4'b1000, 1'b1, 4'b1000);
    step(1'b0, 4'b1111, 1'b1, 4'b0010);
    step(1'b0, 4'b1111, 1'b1, 4'b0100);

    // Backpressure: ch2 beat held for 5 cycles, nothing granted.
    hold = chdata[2];
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b0, 4'b0000);
      chk("stall_out_data", out_data, hold);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      if (i == 0) begin
        for (int c = 0; c < N; c++) chdata[c] = 32'hC0DE_0000 + 32'(c) * 32'h111;
      end
    end
    // Release: next beat (ch3) loads on the same edge the held beat leaves.
    step(1'b0, 4'b1111, 1'b1, 4'b1000);

    // Wrap and sparse: ptr 3 with only ch0 -> ch0, then ptr is 1.
    step(1'b0, 4'b0100, 1'b1, 4'b0100);
    step(1'b0, 4'b0001, 1'b1, 4'b0001);
    step(1'b0, 4'b1111, 1'b1, 4'b0010);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_out_sel", {30'b0, out_sel}, 32'd1);
    chk("drain_out_data", out_data, 32'hC0DE_0111);

    // Reset mid-stream with a beat in the output register.
    step(1'b0, 4'b1111, 1'b1, 4'b0100);
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_reset_out_data", out_data, 32'd0);
    chk("async_reset_out_sel", {30'b0, out_sel}, 32'd0);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 4'b1111, 1'b1, 4'b0001);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);

`ifdef MUX_NX1_STALL_CNT_EN
    // Saturation after a long stall, then clear beats a coincident stall.
    step(1'b0, 4'b0100, 1'b1, 4'b0100);
    step(1'b0, 4'b0100, 1'b0, 4'b0000);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);
    @(posedge clk);
    #1 stall_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_cnt_clr", {16'b0, stall_cnt}, 32'd0);
    stall_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_cnt_after_clr", {16'b0, stall_cnt}, 32'd1);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
`endif

    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats: %0d pending required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr_reg.md
Name: mux_nx1_rr_reg

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with built-in arbitration.
- Each input channel has a valid/ready handshake. The block picks one requesting channel per cycle, round-robin or fixed-priority, and registers the winner's data onto a single valid/ready output.
- It sits between the ALU/datapath result sources and the shared writeback/result bus. It replaces hand-wired 2:1 select trees where sources arrive on independent schedules.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- SELW, $clog2(N), width of the channel index (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  downstream accept.
- out_sel  output  SELW  index of the channel that produced out_data.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer=0 (channel 0 highest priority first).
- Load enable: load = !out_valid || out_ready.
- Grant:
  - When load=1 and in_valid != 0, exactly one winner w is chosen.
  - in_ready[w]=1 combinationally; all other in_ready bits are 0.
  - When load=0 or no request, in_ready=0.
- Transfer: on a rising edge with load=1 and a grant, out_data<=in_data[w], out_sel<=w, out_valid<=1.
- Drain: with load=1 and no request, out_valid<=0. out_data and out_sel hold their last values.
- Stall: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid are stable and in_ready=0.
- Latency and throughput: 1 cycle input to output; 1 beat per cycle sustained while out_ready=1.
- Round-robin (mode=0):
  - Search starts at pointer p and wraps modulo N.
  - After granting w, p<=(w+1) mod N. When w=N-1, p wraps to 0.
  - Pointer updates only on a grant.
- Fixed priority (mode=1):
  - Lowest-index valid channel wins.
  - Pointer is frozen and resumes from its held value when mode returns to 0.
- Mode changes mid-stream take effect on the next arbitration. The beat already in the output register is unaffected.
- in_ready never depends on out_data. It depends combinationally on in_valid, out_valid, out_ready, mode and pointer. Upstream must not make in_valid depend on in_ready.
- Reset asserted mid-transfer: the output beat is discarded immediately (async clear). Channels must re-present their data.
- Non-power-of-two N: pointer values >= N never occur.

Optional Feature:
- Macro: MUX_NX1_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt[15:0].
  - Increments each cycle out_valid=1 && out_ready=0, saturating at 16'hFFFF.
  - Reset value 0.
  - Adds input stall_clr (1 bit), which zeroes the counter synchronously and takes precedence over an increment in the same cycle.
- Without the macro: neither port exists and no counter logic is generated. Functional behaviour is identical.

Decomposition:
- Shared package / include: MODE_RR=1'b0, MODE_FIXED=1'b1, and the stall-counter width constant STALL_CNT_W=16.
- One natural sub-module: rr_arbiter_nx1 (parameter N).
  - Inputs: req[N], ptr[SELW], mode.
  - Outputs: one-hot grant[N], grant index[SELW], any_grant.
  - Purely combinational.
- The top holds the output register, pointer and optional counter, plus the final data select (AND-OR of in_data with grant).

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. First post-reset grant with all valid goes to channel 0.
- Round-robin fairness: mode=0, in_valid=4'b1111 held, out_ready=1, data ch i=32'hA0+i -> out_sel sequence 0,1,2,3,0. Each beat appears 1 cycle after its in_ready pulse.
- Fixed priority: mode=1, in_valid=4'b1010 -> ch1 granted every cycle. Drop ch1 -> ch3 granted. Pointer unchanged when returning to mode=0.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=4'b0000, out_data stable. Raise out_ready -> next beat loaded the same edge, no bubble.
- Wrap and sparse: p=3, in_valid=4'b0001 -> ch0 granted, p becomes 1. in_valid=0 with out_ready=1 -> out_valid drops next cycle.
- MUX_NX1_STALL_CNT_EN: 70000 stalled cycles -> stall_cnt=16'hFFFF. stall_clr together with a stall cycle -> 0.
